// File: rtl/msg_decoder_if.sv
// rtl/msg_decoder_if.sv - data-memory bus between msg_decoder and the shared memory port
interface msg_decoder_if;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rdata;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;

  modport master (
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/msg_decoder.sv
// rtl/msg_decoder.sv - LFSR message decryption engine, bus master on the data memory
module msg_decoder #(
  parameter logic [7:0] MSG_BASE = 8'd64,
  parameter logic [7:0] OUT_BASE = 8'd0,
  parameter int         MIN_PRE  = 10
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  output logic                 Ack,
  msg_decoder_if.master        mem,
  output logic [3:0]           tap_idx,
  output logic                 no_match,
  output logic [6:0]           parity_err_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEARCH, S_DECODE, S_FILL, S_DONE} state_t;

  state_t     state, state_nxt;
  logic       start_q;
  logic [6:0] cnt;
  logic [6:0] wptr;
  logic [6:0] lfsr;
  logic       skip;
  logic [7:0] msg_buf [64];

  logic [6:0] seed;
  logic [6:0] trial;
  logic       pass;
  logic [7:0] dec_byte;
  logic       write_now;
  logic [5:0] ld_idx;

  function automatic logic [6:0] tap_of(input logic [3:0] k);
    case (k)
      4'd0:    tap_of = 7'h60;
      4'd1:    tap_of = 7'h48;
      4'd2:    tap_of = 7'h78;
      4'd3:    tap_of = 7'h72;
      4'd4:    tap_of = 7'h6A;
      4'd5:    tap_of = 7'h69;
      4'd6:    tap_of = 7'h5C;
      4'd7:    tap_of = 7'h7E;
      4'd8:    tap_of = 7'h7B;
      default: tap_of = 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] tap);
    lfsr_step = {s[5:0], ^(s & tap)};
  endfunction

  // Byte 0 is a known space, so its keystream is the LFSR starting state.
  assign seed      = msg_buf[0][6:0] ^ 7'h20;
  // Read data lags the issued address by one cycle.
  assign ld_idx    = cnt[5:0] - 6'd1;
  assign dec_byte  = {1'b0, msg_buf[cnt[5:0]][6:0] ^ lfsr};
  assign write_now = !(skip && dec_byte == 8'h20);

  // Candidate pattern cnt: run it forward from the seed and compare with the preamble keystream.
  always_comb begin
    pass  = 1'b1;
    trial = seed;
    for (int i = 1; i < MIN_PRE; i++) begin
      trial = lfsr_step(trial, tap_of(cnt[3:0]));
      if ((msg_buf[i][6:0] ^ 7'h20) != trial) pass = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and bus/handshake outputs decoded from the current state and counters.
  always_comb begin
    state_nxt     = state;
    Ack           = 1'b0;
    mem.mem_addr  = 8'h00;
    mem.mem_rd_en = 1'b0;
    mem.mem_wr_en = 1'b0;
    mem.mem_wdata = 8'h00;
    case (state)
      S_IDLE: begin
        if (!Start && start_q) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        mem.mem_rd_en = !cnt[6];
        mem.mem_addr  = MSG_BASE + {2'b00, cnt[5:0]};
        if (cnt[6]) state_nxt = S_SEARCH;
      end
      S_SEARCH: begin
        // cnt == 9 is the extra cycle that latches the no-match verdict.
        if (cnt == 7'd9)   state_nxt = S_DONE;
        else if (pass)     state_nxt = S_DECODE;
      end
      S_DECODE: begin
        mem.mem_wr_en = write_now;
        mem.mem_addr  = OUT_BASE + {2'b00, wptr[5:0]};
        mem.mem_wdata = dec_byte;
        if (cnt == 7'd63) begin
          if ((wptr + {6'b0, write_now}) == 7'd64) state_nxt = S_DONE;
          else                                     state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        mem.mem_wr_en = 1'b1;
        mem.mem_addr  = OUT_BASE + {2'b00, wptr[5:0]};
        mem.mem_wdata = 8'h20;
        if (wptr == 7'd63) state_nxt = S_DONE;
      end
      S_DONE: begin
        Ack = 1'b1;
        if (Start) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: counters, buffer capture, pattern result, LFSR and write pointer.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      start_q        <= 1'b0;
      cnt            <= '0;
      wptr           <= '0;
      lfsr           <= '0;
      skip           <= 1'b0;
      tap_idx        <= 4'hF;
      no_match       <= 1'b0;
      parity_err_cnt <= '0;
      for (int i = 0; i < 64; i++) msg_buf[i] <= '0;
    end else begin
      start_q <= Start;
      case (state)
        S_IDLE: begin
          if (state_nxt == S_LOAD) begin
            cnt            <= '0;
            tap_idx        <= 4'hF;
            no_match       <= 1'b0;
            parity_err_cnt <= '0;
          end
        end
        S_LOAD: begin
          cnt <= cnt[6] ? 7'd0 : cnt + 7'd1;
          if (cnt != 7'd0) begin
            msg_buf[ld_idx] <= mem.mem_rdata;
            if (mem.mem_rdata[7] != ^mem.mem_rdata[6:0])
              parity_err_cnt <= parity_err_cnt + 7'd1;
          end
        end
        S_SEARCH: begin
          if (cnt == 7'd9) begin
            no_match <= 1'b1;
          end else if (pass) begin
            tap_idx <= cnt[3:0];
            lfsr    <= seed;
            cnt     <= '0;
            wptr    <= '0;
            skip    <= 1'b1;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        S_DECODE: begin
          lfsr <= lfsr_step(lfsr, tap_of(tap_idx));
          cnt  <= cnt + 7'd1;
          if (write_now) begin
            wptr <= wptr + 7'd1;
            skip <= 1'b0;
          end
        end
        S_FILL: begin
          wptr <= wptr + 7'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
